// File: rtl/uart_tx_fifo.sv
// UART transmitter (LSB-first 8N1) behind a 2^FIFO_AW-entry byte FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_busy,
  output logic       tx_idle,
  output logic       tx_ovf,
  output logic       txd
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_n;
  logic               push, pop, nonempty, baud_last;
  logic [7:0]         head;

  logic [2:0]  state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        txd_n;
`ifdef UART_TX_PARITY_EN
  logic        par, par_n;
`endif

  assign push      = tx_en & ~tx_busy;
  assign nonempty  = (count != '0);
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign head      = mem[rd_ptr];

  always_comb begin
    pop     = 1'b0;
    state_n = state;
    baud_n  = baud_cnt + 16'd1;
    idx_n   = bit_idx;
    shift_n = shift;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        baud_n = '0;
        if (nonempty) begin
          pop     = 1'b1;
          state_n = START;
          idx_n   = '0;
          shift_n = head;
`ifdef UART_TX_PARITY_EN
          par_n   = ^head;
`endif
        end
      end
      START: if (baud_last) begin
        state_n = DATA;
        baud_n  = '0;
      end
      DATA: if (baud_last) begin
        baud_n = '0;
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          idx_n   = bit_idx + 3'd1;
          shift_n = {1'b0, shift[7:1]};
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_last) begin
        state_n = STOP;
        baud_n  = '0;
      end
`endif
      STOP: if (baud_last) begin
        baud_n = '0;
        // Pop in the final stop cycle so consecutive frames abut with no idle gap
        if (nonempty) begin
          pop     = 1'b1;
          state_n = START;
          idx_n   = '0;
          shift_n = head;
`ifdef UART_TX_PARITY_EN
          par_n   = ^head;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
      end
    endcase
  end

  // Line level is derived from the next state so txd is a plain flop
  always_comb begin
    txd_n = 1'b1;
    case (state_n)
      START:  txd_n = 1'b0;
      DATA:   txd_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_n = par_n;
`endif
      default: txd_n = 1'b1;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_n = count + (FIFO_AW+1)'(1);
      2'b01:   count_n = count - (FIFO_AW+1)'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_busy  <= 1'b0;
      tx_idle  <= 1'b1;
      tx_ovf   <= 1'b0;
      txd      <= 1'b1;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count    <= count_n;
      tx_busy  <= (count_n == FULL);
      tx_idle  <= (state_n == IDLE) && (count_n == '0);
      tx_ovf   <= tx_ovf | (tx_en & tx_busy);
      txd      <= txd_n;
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= idx_n;
      shift    <= shift_n;
`ifdef UART_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_DIV=4; follows UART_TX_PARITY_EN if defined.
module tb_uart_tx_fifo;

  localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_en = 1'b0;
  logic       tx_busy, tx_idle, tx_ovf, txd;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_AW(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_en   (tx_en),
    .tx_busy (tx_busy),
    .tx_idle (tx_idle),
    .tx_ovf  (tx_ovf),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bit n: start, 8 data LSB-first, [even parity], stop
  function automatic logic exp_bit(input logic [7:0] b, input int unsigned n);
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
`ifdef UART_TX_PARITY_EN
    if (n == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Cycle c of a frame is the one following edge (first start edge + c)
  task automatic frame(input logic [7:0] b, input int unsigned skip);
    for (int unsigned c = skip; c < NBITS*DIV; c++) begin
      tick();
      if (c == skip) tx_en = 1'b0;
      chk($sformatf("txd_%h_bit%0d_c%0d", b, c/DIV, c%DIV), txd, exp_bit(b, c/DIV));
    end
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_txd", txd, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_idle", tx_idle, 1);
    chk("rst_ovf", tx_ovf, 0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("quiet_txd", txd, 1);
      chk("quiet_idle", tx_idle, 1);
    end

    // Single byte
    tx_data = 8'h11; tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    chk("single_idle_fall", tx_idle, 0);
    chk("single_txd_pre", txd, 1);
    frame(8'h11, 0);
    chk("single_idle_last_stop", tx_idle, 0);
    tick();
    chk("single_idle_rise", tx_idle, 1);
    chk("single_txd_after", txd, 1);

    // Back-to-back
    repeat (5) tick();
    tx_data = 8'h55; tx_en = 1'b1;
    tick();
    tx_data = 8'hAA;
    frame(8'h55, 0);
    frame(8'hAA, 0);
    tick();
    chk("b2b_idle", tx_idle, 1);
    chk("b2b_ovf", tx_ovf, 0);

    // Fill and overflow
    repeat (5) tick();
    tx_data = 8'h10; tx_en = 1'b1;
    tick();
    tx_data = 8'h11;
    tick();
    chk("fill_start_latency", txd, 0);
    chk("fill_busy_2", tx_busy, 0);
    tx_data = 8'h12; tick();
    tx_data = 8'h13; tick();
    chk("fill_busy_4", tx_busy, 0);
    tx_data = 8'h14; tick();
    chk("fill_busy_5", tx_busy, 1);
    chk("fill_ovf_5", tx_ovf, 0);
    tx_data = 8'h15; tick();
    tx_en = 1'b0;
    chk("fill_ovf_6", tx_ovf, 1);
    chk("fill_busy_6", tx_busy, 1);
    frame(8'h10, 5);
    chk("fill_busy_end_f0", tx_busy, 1);
    tick();
    chk("fill_busy_fall", tx_busy, 0);
    chk("fill_f1_start", txd, 0);
    frame(8'h11, 1);
    frame(8'h12, 0);
    frame(8'h13, 0);
    frame(8'h14, 0);
    tick();
    chk("fill_idle", tx_idle, 1);
    chk("fill_ovf_sticky", tx_ovf, 1);
    chk("fill_busy_empty", tx_busy, 0);

    // Push right after busy falls, while the FIFO keeps draining
    rst_n = 1'b0;
    tick(); tick();
    chk("rst2_ovf", tx_ovf, 0);
    rst_n = 1'b1;
    tick();
    tx_data = 8'h20; tx_en = 1'b1; tick();
    tx_data = 8'h21; tick();
    tx_data = 8'h22; tick();
    tx_data = 8'h23; tick();
    tx_data = 8'h24; tick();
    tx_en = 1'b0;
    chk("pp_busy_full", tx_busy, 1);
    frame(8'h20, 4);
    tick();
    chk("pp_busy_fall", tx_busy, 0);
    chk("pp_f1_start", txd, 0);
    tx_data = 8'h25; tx_en = 1'b1;
    frame(8'h21, 1);
    frame(8'h22, 0);
    frame(8'h23, 0);
    frame(8'h24, 0);
    frame(8'h25, 0);
    tick();
    chk("pp_idle", tx_idle, 1);
    chk("pp_ovf", tx_ovf, 0);
    chk("pp_busy", tx_busy, 0);

    // Reset mid-frame during DATA bit 3 with two bytes queued
    repeat (3) tick();
    tx_data = 8'h30; tx_en = 1'b1; tick();
    tx_data = 8'h31; tick();
    tx_data = 8'h32; tick();
    tx_en = 1'b0;
    repeat (16) tick();
    chk("mid_bit3_low", txd, 0);
    chk("mid_busy", tx_busy, 0);
    chk("mid_idle", tx_idle, 0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_idle", tx_idle, 1);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("mid_after_txd", txd, 1);
    end
    chk("mid_after_idle", tx_idle, 1);
    chk("mid_after_busy", tx_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
